systolic_seq_controller: RTL
============================

# systolic_seq_controller

Parametrised next-generation sequencer for the systolic cube. It streams operand-RAM addresses for a runtime-configured number of tiles and run length, and emits the accumulator-clear, per-row skewed enable and ping-pong bank controls. It absorbs downstream back-pressure through a stall input. It sits between the host start/config registers and the cube's operand RAMs and PE arrays.

## Interface
- ARRAY_NUM, 3, PE rows per array; must be ≥ 2; sets skew depth and oRowEn width
- RAM_DEPTH, 2048, operand RAM depth; must be a power of two; AW = $clog2(RAM_DEPTH)
- MAX_LEN, 256, maximum stream length per tile; LW = $clog2(MAX_LEN+1)
- MAX_TILES, 64, maximum tiles per job; TW = $clog2(MAX_TILES+1)
- iClk  in  1  clock
- iRstN  in  1  reset; synchronous, active-low
- iStart  in  1  job start; sampled only in IDLE
- iLen  in  LW  beats per tile (L); latched on accepted start
- iTileNum  in  TW  tiles per job (T); latched on accepted start
- iBaseAddr  in  AW  first address of job; latched on accepted start
- iStall  in  1  downstream back-pressure; freezes sequencing
- oReady  out  1  high in IDLE
- oClearAcc  out  1  one-cycle accumulator clear at the head of each tile
- oAddrValid  out  1  oAddr is a valid read this cycle
- oAddr  out  AW  RAM read address
- oRowEn  out  ARRAY_NUM  row r enabled; bit r is oAddrValid delayed r advancing cycles
- oBank  out  1  ping-pong result bank for current tile
- oTileDone  out  1  one-cycle pulse when a tile has fully drained
- oDone  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- An advancing cycle is a cycle with iStall=0 outside IDLE. Counters, state, pointer, skew shift register and bank change only on advancing cycles.
- Outputs are combinational decodes of registered state, gated by ~iStall:
  - oClearAcc = CLEAR
  - oAddrValid = STREAM
  - oRowEn = skew register, with bit 0 = STREAM
  - oTileDone = DONE, or CLEAR entered from DRAIN
  - oDone = DONE
  - oReady = IDLE and is not gated by iStall.
- IDLE:
  - iStart=1 with L≥1 and T≥1: latch config, ptr←iBaseAddr, tile←0, oBank←0, go to CLEAR.
  - iStart=1 with L=0 or T=0: go to DONE. This gives a single oDone/oTileDone pulse and no addresses.
- CLEAR: 1 advancing cycle, then STREAM.
- STREAM: L advancing cycles. oAddr=ptr. ptr←(ptr+1) mod RAM_DEPTH each beat. Address of beat k of tile t = (iBaseAddr + t·L + k) mod RAM_DEPTH. No multiplier is used.
- DRAIN: ARRAY_NUM−1 advancing cycles, so the last row sees its final beat.
- After DRAIN:
  - tile+1 < T: tile++, oBank toggles, go to CLEAR. The tile-done pulse is coincident with that CLEAR.
  - otherwise: go to DONE.
- DONE: 1 cycle, then IDLE.
- iStart outside IDLE is ignored; config inputs are don't-care after acceptance.
- ptr is never reset between tiles, so tiles are contiguous in RAM; wrap at RAM_DEPTH−1→0.

## Timing
- Reset: from the first edge with iRstN=0, the state is IDLE and all counters, the skew register, ptr and oBank are 0. The only output high is oReady=1.
- Reset mid-job aborts without a oDone pulse.
- Per-tile cycle schedule, with no stall, start accepted at edge E0, tile period P = L + ARRAY_NUM, tile t offset o = t·P:
  - oClearAcc: cycle o+1
  - oAddrValid: cycles o+2 … o+L+1
  - oRowEn[r]: cycles o+2+r … o+L+1+r
  - drain: cycles o+L+2 … o+P
- Job end: oDone and the last oTileDone occur at cycle T·P+1; oReady returns at T·P+2. A new iStart is accepted at T·P+2.
- Stall: each stalled cycle inserts one all-zero cycle (oReady, oAddr and oBank held). The sequence resumes exactly where it left off, with no beat dropped or duplicated. Stall in IDLE has no effect.
- Simultaneous iStall and the last DRAIN cycle: the transition waits for the next advancing cycle.

## Test plan
- **Single tile.** ARRAY_NUM=3, L=4, T=1, base=0x010, no stall.
  - clear at cycle 1; addr 0x010–0x013 valid at cycles 2–5
  - oRowEn[2] high cycles 4–7
  - oDone and oTileDone at cycle 8; oReady at cycle 9
- **Multi-tile.** L=2, T=3, base=0.
  - addresses 0,1 | 2,3 | 4,5
  - oBank 0,1,0
  - oTileDone at cycles 6, 11, 16; oDone at cycle 16
- **Wrap.** RAM_DEPTH=2048, base=0x7FE, L=4, T=1.
  - addresses 0x7FE, 0x7FF, 0x000, 0x001
- **Stall.** L=4; iStall high for 2 cycles at cycle 3 and for 1 cycle in DRAIN.
  - valid addresses still exactly 0..3 in order
  - oDone at cycle 11
  - all pulse outputs 0 while stalled
- **Degenerate and ignored start.**
  - L=0, T=5 gives oDone at cycle 1 and no oAddrValid.
  - iStart pulsed again mid-STREAM has no effect.
- **Reset mid-job.** iRstN=0 for one edge during tile 1 of T=3.
  - next cycle: oReady=1, oBank=0, no oDone
  - a fresh start then runs normally from iBaseAddr

Source files
------------

// File: rtl/systolic_seq_controller.sv
// Systolic cube sequencer: streams operand-RAM addresses per tile and drives
// the accumulator-clear, skewed row enables and ping-pong bank select.
module systolic_seq_controller #(
    parameter int ARRAY_NUM = 3,
    parameter int RAM_DEPTH = 2048,
    parameter int MAX_LEN   = 256,
    parameter int MAX_TILES = 64,
    localparam int AW = $clog2(RAM_DEPTH),
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int TW = $clog2(MAX_TILES + 1)
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    input  logic                 iStart,
    input  logic [LW-1:0]        iLen,
    input  logic [TW-1:0]        iTileNum,
    input  logic [AW-1:0]        iBaseAddr,
    input  logic                 iStall,
    output logic                 oReady,
    output logic                 oClearAcc,
    output logic                 oAddrValid,
    output logic [AW-1:0]        oAddr,
    output logic [ARRAY_NUM-1:0] oRowEn,
    output logic                 oBank,
    output logic                 oTileDone,
    output logic                 oDone
);

    localparam int DW = $clog2(ARRAY_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        len_q, len_d;
    logic [TW-1:0]        tiles_q, tiles_d;
    logic [TW-1:0]        tile_q, tile_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [LW-1:0]        beat_q, beat_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [ARRAY_NUM-2:0] skew_q, skew_d;
    logic                 bank_q, bank_d;
    logic                 from_drain_q, from_drain_d;
    logic                 adv;

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            tiles_q      <= '0;
            tile_q       <= '0;
            ptr_q        <= '0;
            beat_q       <= '0;
            drain_q      <= '0;
            skew_q       <= '0;
            bank_q       <= 1'b0;
            from_drain_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            tiles_q      <= tiles_d;
            tile_q       <= tile_d;
            ptr_q        <= ptr_d;
            beat_q       <= beat_d;
            drain_q      <= drain_d;
            skew_q       <= skew_d;
            bank_q       <= bank_d;
            from_drain_q <= from_drain_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        tiles_d      = tiles_q;
        tile_d       = tile_q;
        ptr_d        = ptr_q;
        beat_d       = beat_q;
        drain_d      = drain_q;
        skew_d       = skew_q;
        bank_d       = bank_q;
        from_drain_d = from_drain_q;
        adv          = (state_q != S_IDLE) && !iStall;

        // skew_q[i] carries row i+1's enable; row 0 is the STREAM decode itself
        if (adv) begin
            skew_d[0] = (state_q == S_STREAM);
            for (int unsigned i = 1; i < ARRAY_NUM - 1; i++) begin
                skew_d[i] = skew_q[i-1];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    if (iLen != '0 && iTileNum != '0) begin
                        len_d        = iLen;
                        tiles_d      = iTileNum;
                        ptr_d        = iBaseAddr;
                        tile_d       = '0;
                        bank_d       = 1'b0;
                        beat_d       = '0;
                        drain_d      = '0;
                        from_drain_d = 1'b0;
                        state_d      = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                if (adv) begin
                    from_drain_d = 1'b0;
                    state_d      = S_STREAM;
                end
            end
            S_STREAM: begin
                if (adv) begin
                    ptr_d = ptr_q + AW'(1);
                    if (beat_q == len_q - LW'(1)) begin
                        beat_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        beat_d = beat_q + LW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (adv) begin
                    if (drain_q == DW'(ARRAY_NUM - 2)) begin
                        drain_d = '0;
                        if (tile_q + TW'(1) < tiles_q) begin
                            tile_d       = tile_q + TW'(1);
                            bank_d       = ~bank_q;
                            from_drain_d = 1'b1;
                            state_d      = S_CLEAR;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
            end
            S_DONE: begin
                if (adv) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign oReady     = (state_q == S_IDLE);
    assign oClearAcc  = (state_q == S_CLEAR) && !iStall;
    assign oAddrValid = (state_q == S_STREAM) && !iStall;
    assign oAddr      = ptr_q;
    assign oRowEn     = {skew_q, (state_q == S_STREAM)} & {ARRAY_NUM{!iStall}};
    assign oBank      = bank_q;
    assign oTileDone  = ((state_q == S_DONE) || (state_q == S_CLEAR && from_drain_q)) && !iStall;
    assign oDone      = (state_q == S_DONE) && !iStall;

endmodule
